// File: rtl/gpr_mac_datapath.sv
// ============================================================================
// gpr_mac_datapath
// ----------------------------------------------------------------------------
// Execution stage that sits directly behind the instruction decoder. It holds
// a 16-entry general purpose register file with three operand read ports
// (A, B, C), one STORE read port (T) and two write ports (X for LOAD data,
// Y for arithmetic results). Arithmetic runs through a two-stage pipeline:
// stage 1 captures operands and the opcode, stage 2 computes the result, and
// the result is committed on the following edge when the decoder raises
// wrt_enb_y.
//
// Supported opcodes:
//   OP_MULT  : RT <= RA * RB
//   OP_ADD   : RT <= RA + RC
//   OP_MULTX : RT <= RA * RB + RC
//   other    : result is zero
// All arithmetic is unsigned and keeps the low DATA_W bits.
//
// Ports:
//   clock           in   system clock, all state updates on the rising edge
//   reset           in   synchronous, active-high; clears GPRs, pipe, STORE bus
//   op_code         in   opcode of the instruction whose read addresses are
//                        presented this cycle
//   rd_adr_a        in   operand A register address (RA)
//   rd_adr_b        in   operand B register address (RB)
//   rd_adr_c        in   operand C register address (RC)
//   rd_adr_t        in   STORE source register address (RT field)
//   wrt_adr_x       in   LOAD destination register
//   wrt_enb_x       in   LOAD commit enable
//   load_data       in   LOAD word, valid while wrt_enb_x is high
//   wrt_adr_y       in   arithmetic destination, presented two cycles after
//                        the operand addresses of the same instruction
//   wrt_enb_y       in   arithmetic commit enable
//   mem_write_data  out  STORE data, registered copy of GPR[rd_adr_t]
// ============================================================================
module gpr_mac_datapath #(
    parameter int         DATA_W   = 32,
    parameter int         ADR_W    = 4,
    parameter logic [7:0] OP_MULT  = 8'h33,
    parameter logic [7:0] OP_ADD   = 8'h34,
    parameter logic [7:0] OP_MULTX = 8'h35
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        op_code,
    input  logic [ADR_W-1:0]  rd_adr_a,
    input  logic [ADR_W-1:0]  rd_adr_b,
    input  logic [ADR_W-1:0]  rd_adr_c,
    input  logic [ADR_W-1:0]  rd_adr_t,
    input  logic [ADR_W-1:0]  wrt_adr_x,
    input  logic              wrt_enb_x,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADR_W-1:0]  wrt_adr_y,
    input  logic              wrt_enb_y,
    output logic [DATA_W-1:0] mem_write_data
);

    localparam int NREG = 1 << ADR_W;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_gpr [NREG];

    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [DATA_W-1:0] r_s1_c;
    logic [7:0]        r_s1_op;
    logic              r_s1_vld;

    logic [DATA_W-1:0] r_s2_res;
    logic              r_s2_vld;

    logic [DATA_W-1:0] r_mem_wr_data;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic              w_y_commit;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_rd_c;
    logic [DATA_W-1:0] w_rd_t;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_sum_ac;
    logic [DATA_W-1:0] w_multx;
    logic [DATA_W-1:0] w_s2_next;

    // A register read with write-through bypass. A same-cycle LOAD takes
    // priority over a same-cycle arithmetic commit because the LOAD also wins
    // the register itself when both target the same address.
    function automatic logic [DATA_W-1:0] bypassRead(
        input logic [ADR_W-1:0]  adr,
        input logic [DATA_W-1:0] gprVal,
        input logic              xEnb,
        input logic [ADR_W-1:0]  xAdr,
        input logic [DATA_W-1:0] xData,
        input logic              yEnb,
        input logic [ADR_W-1:0]  yAdr,
        input logic [DATA_W-1:0] yData
    );
        logic [DATA_W-1:0] val;
        val = gprVal;
        if (yEnb && (yAdr == adr)) begin
            val = yData;
        end
        if (xEnb && (xAdr == adr)) begin
            val = xData;
        end
        return val;
    endfunction

    // An arithmetic commit only happens when stage 2 holds a result that was
    // captured after the last reset. This keeps a reset from letting anything
    // that was in flight land in the register file afterwards, even if the
    // decoder still raises wrt_enb_y on the cycle following reset.
    assign w_y_commit = wrt_enb_y & r_s2_vld;

    // Operand and STORE reads, all bypassed against this cycle's writes.
    assign w_rd_a = bypassRead(rd_adr_a, r_gpr[rd_adr_a], wrt_enb_x, wrt_adr_x,
                               load_data, w_y_commit, wrt_adr_y, r_s2_res);
    assign w_rd_b = bypassRead(rd_adr_b, r_gpr[rd_adr_b], wrt_enb_x, wrt_adr_x,
                               load_data, w_y_commit, wrt_adr_y, r_s2_res);
    assign w_rd_c = bypassRead(rd_adr_c, r_gpr[rd_adr_c], wrt_enb_x, wrt_adr_x,
                               load_data, w_y_commit, wrt_adr_y, r_s2_res);
    assign w_rd_t = bypassRead(rd_adr_t, r_gpr[rd_adr_t], wrt_enb_x, wrt_adr_x,
                               load_data, w_y_commit, wrt_adr_y, r_s2_res);

    // Stage 2 arithmetic. Results are DATA_W wide so products and sums
    // simply drop their carry/high bits.
    assign w_prod   = r_s1_a * r_s1_b;
    assign w_sum_ac = r_s1_a + r_s1_c;
    assign w_multx  = w_prod + r_s1_c;

    // Pick the stage 2 result by the opcode captured in stage 1; unknown
    // opcodes produce zero so a stray commit cannot write garbage.
    always_comb begin
        w_s2_next = '0;
        case (r_s1_op)
            OP_MULT:  w_s2_next = w_prod;
            OP_ADD:   w_s2_next = w_sum_ac;
            OP_MULTX: w_s2_next = w_multx;
            default:  w_s2_next = '0;
        endcase
    end

    // Stage 1: capture the bypassed operands and the opcode every cycle.
    // The valid flag marks that the captured operands belong to an
    // instruction presented after reset was released.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= '0;
            r_s1_op  <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_a   <= w_rd_a;
            r_s1_b   <= w_rd_b;
            r_s1_c   <= w_rd_c;
            r_s1_op  <= op_code;
            r_s1_vld <= 1'b1;
        end
    end

    // Stage 2: register the arithmetic result. One op enters per cycle,
    // there is no stall path.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_res <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_res <= w_s2_next;
            r_s2_vld <= r_s1_vld;
        end
    end

    // Register file writes. The Y commit is applied first and the X commit
    // second, so a LOAD to the same register on the same edge overwrites the
    // arithmetic result (the LOAD belongs to the younger instruction).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            if (w_y_commit) begin
                r_gpr[wrt_adr_y] <= r_s2_res;
            end
            if (wrt_enb_x) begin
                r_gpr[wrt_adr_x] <= load_data;
            end
        end
    end

    // STORE bus: registered every cycle regardless of whether a STORE is
    // actually in progress; the memory side qualifies it with the decoder's
    // write-valid strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_wr_data <= '0;
        end else begin
            r_mem_wr_data <= w_rd_t;
        end
    end

    assign mem_write_data = r_mem_wr_data;

endmodule
